// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send and
// shifts one command byte (odd parity) out on device-generated clock edges.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_done,
  output logic       tx_error
);

  // state     | meaning
  // IDLE      | lines released, ready for a command
  // INHIBIT   | clock held low to abort any device transmission
  // RTS       | data pulled low (start bit) while clock still held
  // SEND      | clock released; data/parity/stop driven on clock falls
  // ACK       | waiting for the device to pull data low on the next fall
  // WAIT_IDLE | waiting for both lines to return high
  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE
  } state_t;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic [CW-1:0] cnt;
  logic [3:0]    bitidx;
  logic [9:0]    frame;
  logic          dat_drive;
  logic          done_q, err_q;

  logic clk_s, dat_s, clk_fall, timeout;

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign clk_fall = clk_prev & ~clk_s;
  assign timeout  = ((state == SEND) || (state == ACK) || (state == WAIT_IDLE))
                    && (cnt == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cmd_valid) state_nxt = INHIBIT;
      INHIBIT:   if (cnt == INH_LAST) state_nxt = RTS;
      RTS:       state_nxt = SEND;
      SEND: begin
        if (timeout)                         state_nxt = IDLE;
        else if (clk_fall && bitidx == 4'd9) state_nxt = ACK;
      end
      ACK: begin
        if (timeout)       state_nxt = IDLE;
        else if (clk_fall) state_nxt = dat_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (timeout || (clk_s && dat_s)) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == IDLE);
    ps2_clk_oe = (state == INHIBIT) || (state == RTS);
    ps2_dat_oe = dat_drive && ((state == RTS) || (state == SEND));
    tx_done    = done_q;
    tx_error   = err_q;
  end

  // Datapath: synchronisers, shared inhibit/timeout counter, bit shifter, status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_prev  <= 1'b1;
      cnt       <= '0;
      bitidx    <= '0;
      frame     <= '0;
      dat_drive <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_s;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          dat_drive <= 1'b0;
          if (cmd_valid) begin
            frame <= {1'b1, ~^cmd_data, cmd_data};
            cnt   <= '0;
          end
        end
        INHIBIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == INH_LAST) dat_drive <= 1'b1;
        end
        RTS: begin
          cnt    <= '0;
          bitidx <= '0;
        end
        SEND: begin
          cnt <= cnt + CW'(1);
          if (timeout) begin
            dat_drive <= 1'b0;
            err_q     <= 1'b1;
          end else if (clk_fall) begin
            dat_drive <= ~frame[bitidx];
            bitidx    <= bitidx + 4'd1;
          end
        end
        ACK: begin
          cnt       <= cnt + CW'(1);
          dat_drive <= 1'b0;
          if (timeout || (clk_fall && dat_s)) err_q <= 1'b1;
        end
        WAIT_IDLE: begin
          cnt <= cnt + CW'(1);
          if (timeout)             err_q  <= 1'b1;
          else if (clk_s && dat_s) done_q <= 1'b1;
        end
        default: dat_drive <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: wired-AND PS/2 lines with a simple device model,
// table-driven command vectors plus timeout, reset and busy-ignore sequences.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 600;
  localparam int H   = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if ((tx_done && prev_done) || (tx_error && prev_err)) wide_cnt++;
    prev_done = tx_done;
    prev_err  = tx_error;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] cmd, input bit meas, output int lat);
    int t;
    t = 0;
    @(negedge clock);
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clock); t++; end
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    lat = 1;
    if (meas)
      while (ps2_dat_oe !== 1'b1 && lat < 200) begin @(negedge clock); lat++; end
  endtask

  task automatic device(input bit ack, input int nclk, output logic [9:0] bits, output bit ok);
    int t;
    ok = 1'b1;
    bits = '0;
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 200) begin @(negedge clock); t++; end
    t = 0;
    while (ps2_clk_oe !== 1'b0 && t < 200) begin @(negedge clock); t++; end
    if (t >= 200) ok = 1'b0;
    repeat (H) @(negedge clock);
    for (int k = 0; k < nclk; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      dev_clk_low = 1'b0;
      if (k < 10) bits[k] = ps2_dat_in;
      if (k == 9 && ack) dev_dat_low = 1'b1;
      repeat (H) @(negedge clock);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_status(input int d0, input int e0);
    int t;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 200) begin @(posedge clock); t++; end
    repeat (3) @(negedge clock);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] cmd, input bit ack,
                         input bit par, input int exp_done, input int exp_err);
    int d0, e0, lat;
    logic [9:0] bits;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    send(cmd, 1'b1, lat);
    chk({tag, "_latency"}, lat, INH + 1);
    device(ack, 11, bits, ok);
    chk({tag, "_clk_release"}, {31'd0, ok}, 1);
    wait_status(d0, e0);
    chk({tag, "_data"}, {24'd0, bits[7:0]}, {24'd0, cmd});
    chk({tag, "_parity"}, {31'd0, bits[8]}, {31'd0, par});
    chk({tag, "_stop"}, {31'd0, bits[9]}, 1);
    chk({tag, "_done"}, done_cnt - d0, exp_done);
    chk({tag, "_error"}, err_cnt - e0, exp_err);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 1);
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    bit         par;
    int         done;
    int         err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, e0, lat, n;
    logic [9:0] bits;
    bit ok;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 0};
    vecs[4] = '{8'hED, 1'b0, 1'b1, 0, 1};

    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    chk("rst_done", {31'd0, tx_done}, 0);
    chk("rst_error", {31'd0, tx_error}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].ack, vecs[i].par,
              vecs[i].done, vecs[i].err);

    // Device never clocks: timeout measured from clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h55, 1'b1, lat);
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 50) begin @(negedge clock); n++; end
    n = 0;
    while (tx_error !== 1'b1 && n < TO + 50) begin @(negedge clock); n++; end
    chk("to_cycles", n, TO);
    chk("to_clk_oe", {31'd0, ps2_clk_oe}, 0);
    chk("to_dat_oe", {31'd0, ps2_dat_oe}, 0);
    chk("to_ready", {31'd0, cmd_ready}, 1);
    repeat (3) @(negedge clock);
    chk("to_error", err_cnt - e0, 1);
    chk("to_done", done_cnt - d0, 0);

    // Reset while bit 3 of 0x00 (driven low) is on the line.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00, 1'b0, lat);
    device(1'b0, 4, bits, ok);
    chk("rmid_bit3_driven", {31'd0, ps2_dat_oe}, 1);
    chk("rmid_bits", {28'd0, bits[3:0]}, 0);
    #3 reset = 1'b0;
    #1;
    chk("rmid_clk_oe", {31'd0, ps2_clk_oe}, 0);
    chk("rmid_dat_oe", {31'd0, ps2_dat_oe}, 0);
    chk("rmid_ready", {31'd0, cmd_ready}, 1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("rmid_no_done", done_cnt - d0, 0);
    chk("rmid_no_error", err_cnt - e0, 0);
    run_vec("post_reset", 8'hF4, 1'b1, 1'b0, 1, 0);

    // A second request during INHIBIT must be ignored.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hED, 1'b0, lat);
    repeat (5) @(negedge clock);
    chk("busy_ready", {31'd0, cmd_ready}, 0);
    cmd_data  = 8'hAA;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    device(1'b1, 11, bits, ok);
    wait_status(d0, e0);
    chk("busy_data", {24'd0, bits[7:0]}, 32'hED);
    repeat (60) @(negedge clock);
    chk("busy_done", done_cnt - d0, 1);
    chk("busy_error", err_cnt - e0, 0);
    chk("busy_idle_clk", {31'd0, ps2_clk_oe}, 0);
    chk("busy_idle_ready", {31'd0, cmd_ready}, 1);

    chk("pulse_overlap", both_cnt, 0);
    chk("pulse_width", wide_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
